// File: rtl/obstacle_tessellator.sv
// rtl/obstacle_tessellator.sv - expands lane obstacle words into a stream of coloured triangle vertices
// Optional macro OBSTACLE_SIDE_FACES_EN: trains also emit both side faces (8 triangles instead of 4).
module obstacle_tessellator #(
  parameter int          COORD_W     = 16,
  parameter int          LANE_PITCH  = 64,
  parameter int          H_LOW       = 16,
  parameter int          H_HIGH      = 48,
  parameter int          H_TRAIN     = 64,
  parameter int          D_TRAIN     = 256,
  parameter int          Z_SHIFT     = 2,
  parameter logic [15:0] COLOR_LOW   = 16'hF800,
  parameter logic [15:0] COLOR_HIGH  = 16'hFFE0,
  parameter logic [15:0] COLOR_TRAIN = 16'h001F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          obstacle,
  input  logic                 obstacle_valid,
  input  logic                 done_in,
  output logic                 ready,
  output logic [3*COORD_W-1:0] vertex,
  output logic [15:0]          color,
  output logic                 vertex_valid,
  input  logic                 vertex_ready,
  output logic                 new_triangle,
  output logic                 done_out
);
  typedef enum logic [1:0] {IDLE, EMIT, FLUSH} state_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  localparam coord_t PITCH = coord_t'(LANE_PITCH);
  localparam coord_t HALF  = coord_t'(LANE_PITCH / 2);
  localparam coord_t ONE   = coord_t'(1);
`ifdef OBSTACLE_SIDE_FACES_EN
  localparam logic [2:0] TRAIN_LAST = 3'd7;
`else
  localparam logic [2:0] TRAIN_LAST = 3'd3;
`endif

  state_t      state, state_n;
  logic        pending;
  coord_t      xl, xr, h, zf, zb;
  logic [2:0]  tri_idx, tri_last;
  logic [1:0]  corner;

  logic [1:0]  ty, ln;
  logic        nz_in;
  coord_t      h_in, d_in, xl_in, zf_in;
  logic [15:0] color_in;
  logic [2:0]  last_in;
  logic        accept, xfer, last_vtx;

  // Lane 3 is an invalid lane and decodes as "no obstacle".
  always_comb begin
    ln       = obstacle[13:12];
    ty       = (ln == 2'd3) ? 2'd0 : obstacle[15:14];
    h_in     = '0;
    d_in     = '0;
    color_in = '0;
    last_in  = '0;
    case (ty)
      2'd1: begin h_in = coord_t'(H_LOW);   color_in = COLOR_LOW;   last_in = 3'd1; end
      2'd2: begin h_in = coord_t'(H_HIGH);  color_in = COLOR_HIGH;  last_in = 3'd1; end
      2'd3: begin h_in = coord_t'(H_TRAIN); color_in = COLOR_TRAIN; last_in = TRAIN_LAST;
                  d_in = coord_t'(D_TRAIN); end
      default: ;
    endcase
    nz_in = (ty != 2'd0);
    xl_in = (coord_t'(ln) - ONE) * PITCH - HALF;
    zf_in = coord_t'(obstacle[11:0]) << Z_SHIFT;
  end

  assign ready    = (state == IDLE) && !pending && !rst;
  assign accept   = obstacle_valid && ready;
  assign xfer     = vertex_valid && vertex_ready;
  assign last_vtx = (tri_idx == tri_last) && (corner == 2'd2);

  always_comb begin
    state_n      = state;
    vertex_valid = 1'b0;
    done_out     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && nz_in) state_n = EMIT;
        else if (pending)    state_n = FLUSH;
      end
      EMIT: begin
        vertex_valid = 1'b1;
        if (xfer && last_vtx) state_n = (pending || done_in) ? FLUSH : IDLE;
      end
      FLUSH: begin
        done_out = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign new_triangle = vertex_valid && (corner == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      xl       <= '0;
      xr       <= '0;
      h        <= '0;
      zf       <= '0;
      zb       <= '0;
      color    <= '0;
      tri_idx  <= '0;
      tri_last <= '0;
      corner   <= '0;
    end else begin
      state   <= state_n;
      pending <= ((state == FLUSH) ? 1'b0 : pending) | done_in;
      if (accept && nz_in) begin
        xl       <= xl_in;
        xr       <= xl_in + PITCH;
        h        <= h_in;
        zf       <= zf_in;
        zb       <= zf_in + d_in;
        color    <= color_in;
        tri_last <= last_in;
        tri_idx  <= '0;
        corner   <= '0;
      end else if (state == EMIT && xfer && !last_vtx) begin
        if (corner == 2'd2) begin
          corner  <= '0;
          tri_idx <= tri_idx + 3'd1;
        end else begin
          corner  <= corner + 2'd1;
        end
      end
    end
  end

  // Per triangle, three corners of {use xr, y=h, z=zb}; the index holds after the last vertex.
  logic [8:0] pat;
  logic [2:0] sel;
  always_comb begin
    case (tri_idx)
      3'd0:    pat = 9'b000_100_010;
      3'd1:    pat = 9'b100_110_010;
      3'd2:    pat = 9'b010_110_011;
      3'd3:    pat = 9'b110_111_011;
      3'd4:    pat = 9'b000_010_001;
      3'd5:    pat = 9'b010_011_001;
      3'd6:    pat = 9'b100_110_101;
      default: pat = 9'b110_111_101;
    endcase
    case (corner)
      2'd0:    sel = pat[8:6];
      2'd1:    sel = pat[5:3];
      default: sel = pat[2:0];
    endcase
    vertex = {(sel[2] ? xr : xl), (sel[1] ? h : '0), (sel[0] ? zb : zf)};
  end
endmodule

// File: tb/tb_obstacle_tessellator.sv
// tb/tb_obstacle_tessellator.sv - vector-table, corner-case and randomized checks of obstacle_tessellator
module tb_obstacle_tessellator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] obstacle = '0;
  logic        obstacle_valid = 1'b0;
  logic        done_in = 1'b0;
  logic        vertex_ready = 1'b0;
  logic        ready, vertex_valid, new_triangle, done_out;
  logic [47:0] vertex;
  logic [15:0] color;

  always #5 clk = ~clk;

  obstacle_tessellator dut (
    .clk(clk), .rst(rst), .obstacle(obstacle), .obstacle_valid(obstacle_valid),
    .done_in(done_in), .ready(ready), .vertex(vertex), .color(color),
    .vertex_valid(vertex_valid), .vertex_ready(vertex_ready),
    .new_triangle(new_triangle), .done_out(done_out)
  );

`ifdef OBSTACLE_SIDE_FACES_EN
  localparam int TRAIN_V = 24;
`else
  localparam int TRAIN_V = 12;
`endif

  typedef struct {int x; int y; int z; int c; bit nt;} vtx_t;
  typedef struct {logic [15:0] w; int n; int fx; int fy; int fz; int c;} vec_t;

  int   applied = 0;
  int   miscompares = 0;
  vtx_t exp_q[$];
  vtx_t got_q[$];
  vec_t tbl[10];

  function automatic int vx(); return int'($signed(vertex[47:32])); endfunction
  function automatic int vy(); return int'($signed(vertex[31:16])); endfunction
  function automatic int vz(); return int'($signed(vertex[15:0]));  endfunction

  task automatic check(input string name, input int act, input int expv);
    applied++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_tri(input int ax, input int ay, input int az, input int bx, input int by,
                          input int bz, input int cx, input int cy, input int cz, input int c);
    exp_q.push_back('{ax, ay, az, c, 1'b1});
    exp_q.push_back('{bx, by, bz, c, 1'b0});
    exp_q.push_back('{cx, cy, cz, c, 1'b0});
  endtask

  // Reference: the geometry of each obstacle as a list of vertices in emission order.
  task automatic build_model(input logic [15:0] w);
    int ty, ln, xl, xr, h, zf, zb, c;
    ty = int'(w[15:14]);
    ln = int'(w[13:12]);
    exp_q.delete();
    if (ln == 3) ty = 0;
    if (ty == 0) return;
    h  = (ty == 1) ? 16 : (ty == 2) ? 48 : 64;
    c  = (ty == 1) ? 'hF800 : (ty == 2) ? 'hFFE0 : 'h001F;
    xl = (ln - 1) * 64 - 32;
    xr = xl + 64;
    zf = int'(w[11:0]) * 4;
    zb = zf + ((ty == 3) ? 256 : 0);
    push_tri(xl, 0, zf, xr, 0, zf, xl, h, zf, c);
    push_tri(xr, 0, zf, xr, h, zf, xl, h, zf, c);
    if (ty == 3) begin
      push_tri(xl, h, zf, xr, h, zf, xl, h, zb, c);
      push_tri(xr, h, zf, xr, h, zb, xl, h, zb, c);
`ifdef OBSTACLE_SIDE_FACES_EN
      push_tri(xl, 0, zf, xl, h, zf, xl, 0, zb, c);
      push_tri(xl, h, zf, xl, h, zb, xl, 0, zb, c);
      push_tri(xr, 0, zf, xr, h, zf, xr, 0, zb, c);
      push_tri(xr, h, zf, xr, h, zb, xr, 0, zb, c);
`endif
    end
  endtask

  task automatic post(input bit dn);
    check("valid_after", vertex_valid, 0);
    check("done_out", done_out, dn);
    if (dn) begin
      check("ready_in_flush", ready, 0);
      @(negedge clk);
      check("done_out_once", done_out, 0);
    end
    check("ready_after", ready, 1);
  endtask

  // Called and returns at a negedge. rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run(input logic [15:0] w, input bit dn, input int rmode);
    int t, cyc, hx, hy, hz, hc;
    bit stalled;
    vtx_t e;
    got_q.delete();
    build_model(w);
    t = 0;
    while (!ready && t < 50) begin @(negedge clk); t++; end
    check("ready_before_send", ready, 1);
    obstacle = w; obstacle_valid = 1'b1; done_in = dn;
    @(negedge clk);
    obstacle_valid = 1'b0; done_in = 1'b0;
    check("first_vertex_latency", vertex_valid, int'(exp_q.size() > 0));
    if (exp_q.size() == 0) begin
      if (dn) begin
        check("pending_ready", ready, 0);
        check("done_early", done_out, 0);
        @(negedge clk);
      end
      post(dn);
      return;
    end
    cyc = 0; stalled = 0; hx = 0; hy = 0; hz = 0; hc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      case (rmode)
        0:       vertex_ready = 1'b1;
        1:       vertex_ready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        default: vertex_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        check("hold_x", vx(), hx); check("hold_y", vy(), hy);
        check("hold_z", vz(), hz); check("hold_color", int'(color), hc);
      end
      if (!vertex_valid) begin
        check("no_bubble", vertex_valid, 1);
        break;
      end else if (vertex_ready) begin
        e = exp_q.pop_front();
        got_q.push_back('{vx(), vy(), vz(), int'(color), new_triangle});
        check("vx", vx(), e.x); check("vy", vy(), e.y); check("vz", vz(), e.z);
        check("color", int'(color), e.c); check("new_triangle", new_triangle, int'(e.nt));
        stalled = 0;
      end else begin
        stalled = 1; hx = vx(); hy = vy(); hz = vz(); hc = int'(color);
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      check("vertices_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    vertex_ready = 1'b0;
    post(dn);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h500A, 6,       -32, 0, 40,    'hF800};
    tbl[1] = '{16'h9001, 6,       -32, 0, 4,     'hFFE0};
    tbl[2] = '{16'hC000, TRAIN_V, -96, 0, 0,     'h001F};
    tbl[3] = '{16'h3000, 0,       0,   0, 0,     0};
    tbl[4] = '{16'h0123, 0,       0,   0, 0,     0};
    tbl[5] = '{16'h6FFF, 6,       32,  0, 16380, 'hF800};
    tbl[6] = '{16'hFFFF, 0,       0,   0, 0,     0};
    tbl[7] = '{16'hE7FF, TRAIN_V, 32,  0, 8188,  'h001F};
    tbl[8] = '{16'h4000, 6,       -96, 0, 0,     'hF800};
    tbl[9] = '{16'hB800, 0,       0,   0, 0,     0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_vertex_valid", vertex_valid, 0);
    check("rst_new_triangle", new_triangle, 0);
    check("rst_done_out", done_out, 0);
    check("rst_vx", vx(), 0); check("rst_vy", vy(), 0); check("rst_vz", vz(), 0);
    check("rst_color", int'(color), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ready, 1);

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].w, 1'b0, 0);
      check("tbl_count", got_q.size(), tbl[i].n);
      if (got_q.size() > 0) begin
        check("tbl_first_x", got_q[0].x, tbl[i].fx);
        check("tbl_first_y", got_q[0].y, tbl[i].fy);
        check("tbl_first_z", got_q[0].z, tbl[i].fz);
        check("tbl_first_color", got_q[0].c, tbl[i].c);
      end
    end

    run(16'hC000, 1'b0, 0);
    if (got_q.size() >= 9) begin
      check("train_v9_x", got_q[8].x, -96);
      check("train_v9_y", got_q[8].y, 64);
      check("train_v9_z", got_q[8].z, 256);
    end else check("train_v9_present", got_q.size(), TRAIN_V);

    run(16'h9001, 1'b0, 1);
    check("stall_count", got_q.size(), 6);

    run(16'h500A, 1'b1, 0);
    check("done_case_count", got_q.size(), 6);

    // done_in with no obstacle in flight
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    check("lone_done_ready", ready, 0);
    check("lone_done_early", done_out, 0);
    @(negedge clk);
    check("lone_done_pulse", done_out, 1);
    @(negedge clk);
    check("lone_done_end", done_out, 0);
    check("lone_done_ready_back", ready, 1);

    run(16'h3000, 1'b0, 0);
    check("lane3_a_count", got_q.size(), 0);
    run(16'h7000, 1'b0, 0);
    check("lane3_b_count", got_q.size(), 0);
    run(16'h6000, 1'b0, 0);
    check("lane2_low_count", got_q.size(), 6);

    // reset in the middle of a train, with a done pending
    obstacle = 16'hC000; obstacle_valid = 1'b1; done_in = 1'b1;
    @(negedge clk);
    obstacle_valid = 1'b0; done_in = 1'b0; vertex_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", vertex_valid, 1);
    check("pre_rst_x", vx(), -32);
    check("pre_rst_new_triangle", new_triangle, 1);
    rst = 1'b1; vertex_ready = 1'b0;
    #1;
    check("rst_cycle_ready", ready, 0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_valid", vertex_valid, 0);
    check("post_rst_vx", vx(), 0);
    for (int k = 0; k < 6; k++) begin
      check("post_rst_no_done", done_out, 0);
      @(negedge clk);
    end
    run(16'h500A, 1'b0, 0);
    check("post_rst_restart_count", got_q.size(), 6);
    if (got_q.size() > 0) check("post_rst_restart_x", got_q[0].x, -32);

    for (int r = 0; r < 40; r++) begin
      run(16'($urandom), 1'($urandom_range(0, 3) == 0), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
